// File: rtl/dac_mix_sched.sv
// Four-channel sample mixer feeding a sigma-delta DAC.
// Each frame it sums the attenuated hold registers, saturates the sum and presents it in excess code.

module dac_mix_sched_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [15:0] data,
    input  logic [2:0]  vol,
    output logic [18:0] term
);
    logic signed [15:0] hold_q, hold_d;
    logic signed [15:0] shifted;

    always_comb begin
        hold_d = hold_q;
        if (valid) hold_d = data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    // vol k shifts by 7-k; vol 0 mutes the lane entirely
    always_comb begin
        shifted = hold_q >>> (3'd7 - vol);
        term    = (vol == 3'd0) ? 19'd0 : {{3{shifted[15]}}, shifted};
    end
endmodule

module dac_mix_sched #(
    parameter int MSBI = 16,
    parameter int DIV  = 64
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ENABLE,
    input  logic [15:0]     CH0_DATA,
    input  logic [15:0]     CH1_DATA,
    input  logic [15:0]     CH2_DATA,
    input  logic [15:0]     CH3_DATA,
    input  logic            CH0_VALID,
    input  logic            CH1_VALID,
    input  logic            CH2_VALID,
    input  logic            CH3_VALID,
    input  logic [2:0]      VOL0,
    input  logic [2:0]      VOL1,
    input  logic [2:0]      VOL2,
    input  logic [2:0]      VOL3,
    output logic [MSBI:0]   DACIN,
    output logic            DAC_STB,
    output logic            CLIP,
    output logic            BUSY
);
    localparam int NUM_LANES = 4;
    localparam int CW        = 26;
    localparam logic [15:0]          CNT_LAST = 16'(DIV - 1);
    localparam logic [MSBI:0]        MID      = {1'b1, {MSBI{1'b0}}};
    localparam logic [MSBI:0]        WORD_MAX = {1'b0, {MSBI{1'b1}}};
    localparam logic [MSBI:0]        WORD_MIN = {1'b1, {MSBI{1'b0}}};
    localparam logic signed [CW-1:0] SAT_MAX  = $signed({{(CW-MSBI){1'b0}}, {MSBI{1'b1}}});
    localparam logic signed [CW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_ACC0, S_ACC1, S_ACC2, S_ACC3, S_SAT, S_OUT
    } state_t;

    logic [NUM_LANES-1:0][15:0] ch_data;
    logic [NUM_LANES-1:0]       ch_valid;
    logic [NUM_LANES-1:0][2:0]  ch_vol;
    logic [NUM_LANES-1:0][18:0] lane_term;

    assign ch_data  = {CH3_DATA, CH2_DATA, CH1_DATA, CH0_DATA};
    assign ch_valid = {CH3_VALID, CH2_VALID, CH1_VALID, CH0_VALID};
    assign ch_vol   = {VOL3, VOL2, VOL1, VOL0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dac_mix_sched_lane u_lane (
            .clk   (CLK),
            .rst_n (RESET_N),
            .valid (ch_valid[i]),
            .data  (ch_data[i]),
            .vol   (ch_vol[i]),
            .term  (lane_term[i])
        );
    end

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           en_q, en_d;
    logic [18:0]    acc_q, acc_d;
    logic [MSBI:0]  dac_q, dac_d;
    logic           clip_q, clip_d;
    logic           tick;
    logic signed [CW-1:0] acc_ext;
    logic [MSBI:0]  sat_word;
    logic           sat_hi, sat_lo;

    // en_q delays the first count by one edge so a fresh enable or reset
    // release sees its first tick a full DIV clocks later
    always_comb begin
        tick  = ENABLE && en_q && (cnt_q == CNT_LAST);
        en_d  = ENABLE;
        cnt_d = cnt_q;
        if (!ENABLE)    cnt_d = '0;
        else if (en_q)  cnt_d = (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
    end

    always_comb begin
        acc_ext  = {{(CW-19){acc_q[18]}}, acc_q};
        sat_hi   = acc_ext > SAT_MAX;
        sat_lo   = acc_ext < SAT_MIN;
        sat_word = acc_ext[MSBI:0];
        if (sat_hi) sat_word = WORD_MAX;
        if (sat_lo) sat_word = WORD_MIN;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dac_d   = dac_q;
        clip_d  = clip_q;
        case (state_q)
            S_IDLE: if (tick) begin
                state_d = S_ACC0;
                acc_d   = '0;
            end
            S_ACC0: begin acc_d = acc_q + lane_term[0]; state_d = S_ACC1; end
            S_ACC1: begin acc_d = acc_q + lane_term[1]; state_d = S_ACC2; end
            S_ACC2: begin acc_d = acc_q + lane_term[2]; state_d = S_ACC3; end
            S_ACC3: begin acc_d = acc_q + lane_term[3]; state_d = S_SAT;  end
            // loading here makes DACIN change exactly in the OUT cycle, alongside DAC_STB
            S_SAT: begin
                dac_d   = {~sat_word[MSBI], sat_word[MSBI-1:0]};
                if (sat_hi || sat_lo) clip_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!ENABLE) begin
            state_d = S_IDLE;
            clip_d  = 1'b0;
            dac_d   = MID;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            acc_q   <= '0;
            dac_q   <= MID;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            acc_q   <= acc_d;
            dac_q   <= dac_d;
            clip_q  <= clip_d;
        end
    end

    assign DACIN   = dac_q;
    assign DAC_STB = (state_q == S_OUT);
    assign CLIP    = clip_q;
    assign BUSY    = (state_q != S_IDLE);
endmodule
